// File: rtl/attn_ctrl_pkg.sv
// Shared definitions for the attention-stage controllers.
package attn_ctrl_pkg;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_NUM_TILES = 16;
    localparam int unsigned DEF_NUM_HEADS = 8;
    localparam int unsigned DEF_ACC_LAT   = 2;

    // One-hot controller states.
    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000001,
        ST_CLEAR   = 6'b000010,
        ST_ACCUM   = 6'b000100,
        ST_DRAIN   = 6'b001000,
        ST_COMPARE = 6'b010000,
        ST_CAPTURE = 6'b100000
    } state_e;

    // Index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/head_prune_ctrl_if.sv
// Tile handshake and accumulator control bundle between array, controller and accumulator.
interface head_prune_ctrl_if;

    logic tile_valid;
    logic tile_ready;
    logic acc_clear;
    logic acc_enable;
    logic acc_compare;
    logic acc_prune;

    modport master (
        input  tile_valid,
        input  acc_prune,
        output tile_ready,
        output acc_clear,
        output acc_enable,
        output acc_compare
    );

    modport slave (
        output tile_valid,
        output acc_prune,
        input  tile_ready,
        input  acc_clear,
        input  acc_enable,
        input  acc_compare
    );

endinterface

// File: rtl/head_prune_ctrl_tile_counter.sv
// Loadable up/down counter with a terminal-count flag.
module tile_counter #(
    parameter int unsigned W    = 4,
    parameter int unsigned LOAD = 0,
    parameter int unsigned TERM = 0,
    parameter bit          DOWN = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tc_c
);

    logic [W-1:0] cnt;

    // Count register: load has priority over counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(LOAD);
        end else if (en) begin
            cnt <= DOWN ? cnt - W'(1) : cnt + W'(1);
        end
    end

    assign tc_c = (cnt == W'(TERM));

endmodule

// File: rtl/head_prune_ctrl.sv
// Per-head Q*K absolute-sum pruning sequencer: drives the accumulator and builds the prune mask.
module head_prune_ctrl
    import attn_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned NUM_TILES = DEF_NUM_TILES,
    parameter int unsigned NUM_HEADS = DEF_NUM_HEADS,
    parameter int unsigned ACC_LAT   = DEF_ACC_LAT,
    localparam int unsigned HEAD_W   = clog2_min1(NUM_HEADS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    head_prune_ctrl_if.master     bus,
    output logic [HEAD_W-1:0]     head_idx,
    output logic [NUM_HEADS-1:0]  prune_mask,
    output logic [HEAD_W:0]       prune_cnt,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned PCNT_W     = HEAD_W + 1;
    localparam int unsigned TILE_W     = clog2_min1(NUM_TILES + 1);
    localparam int unsigned DRAIN_W    = clog2_min1(ACC_LAT + 2);
    localparam int unsigned DRAIN_LOAD = (ACC_LAT > 0) ? ACC_LAT - 1 : 0;

    // The controller never touches data; WIDTH only has to describe a real datapath.
    if (WIDTH == 0 || NUM_TILES == 0 || NUM_HEADS == 0) begin : g_param_chk
        $error("head_prune_ctrl: WIDTH, NUM_TILES and NUM_HEADS must be nonzero");
    end

    state_e state;
    state_e state_next;
    logic   handshake_c;
    logic   last_head_c;
    logic   tile_load_c;
    logic   tile_en_c;
    logic   tile_tc_c;
    logic   drain_load_c;
    logic   drain_en_c;
    logic   drain_tc_c;

    assign handshake_c = bus.tile_valid && (state == ST_ACCUM);
    assign last_head_c = (head_idx == HEAD_W'(NUM_HEADS - 1));

    // Moore decodes straight off the one-hot state flops; acc_enable follows the handshake.
    assign bus.tile_ready  = (state == ST_ACCUM);
    assign bus.acc_clear   = (state == ST_CLEAR);
    assign bus.acc_compare = (state == ST_COMPARE);
    assign bus.acc_enable  = handshake_c;
    assign busy            = (state != ST_IDLE);

    tile_counter #(
        .W    (TILE_W),
        .LOAD (0),
        .TERM (NUM_TILES - 1),
        .DOWN (1'b0)
    ) u_tile_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (tile_load_c),
        .en    (tile_en_c),
        .tc_c  (tile_tc_c)
    );

    tile_counter #(
        .W    (DRAIN_W),
        .LOAD (DRAIN_LOAD),
        .TERM (0),
        .DOWN (1'b1)
    ) u_drain_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (drain_load_c),
        .en    (drain_en_c),
        .tc_c  (drain_tc_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and counter control.
    always_comb begin
        state_next   = state;
        tile_load_c  = 1'b0;
        tile_en_c    = 1'b0;
        drain_load_c = 1'b0;
        drain_en_c   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                tile_load_c = 1'b1;
                state_next  = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (handshake_c) begin
                    tile_en_c = 1'b1;
                    if (tile_tc_c) begin
                        if (ACC_LAT == 0) begin
                            state_next = ST_COMPARE;
                        end else begin
                            drain_load_c = 1'b1;
                            state_next   = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_tc_c) begin
                    state_next = ST_COMPARE;
                end else begin
                    drain_en_c = 1'b1;
                end
            end
            ST_COMPARE: begin
                state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_next = last_head_c ? ST_IDLE : ST_CLEAR;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Head index, prune mask/count and the end-of-pass pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_idx   <= '0;
            prune_mask <= '0;
            prune_cnt  <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((state == ST_IDLE) && start) begin
                head_idx   <= '0;
                prune_mask <= '0;
                prune_cnt  <= '0;
            end
            if (state == ST_CAPTURE) begin
                prune_mask[head_idx] <= bus.acc_prune;
                prune_cnt            <= prune_cnt + PCNT_W'(bus.acc_prune);
                if (last_head_c) begin
                    done <= 1'b1;
                end else begin
                    head_idx <= head_idx + HEAD_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_head_prune_ctrl.sv
// Directed self-checking bench for head_prune_ctrl with a prune-mask scoreboard.
module tb_head_prune_ctrl;
    import attn_ctrl_pkg::*;

    localparam int unsigned NH = 8;
    localparam int unsigned NT = 16;
    localparam int unsigned AL = 2;
    localparam int unsigned HW = 3;

    typedef struct {
        logic [NH-1:0] mask;
        logic [HW:0]   cnt;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic start6;

    logic [HW-1:0] head_idx;
    logic [NH-1:0] prune_mask;
    logic [HW:0]   prune_cnt;
    logic          busy;
    logic          done;

    logic [0:0]    head_idx6;
    logic [0:0]    prune_mask6;
    logic [1:0]    prune_cnt6;
    logic          busy6;
    logic          done6;

    head_prune_ctrl_if bus ();
    head_prune_ctrl_if bus6 ();

    head_prune_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .head_idx   (head_idx),
        .prune_mask (prune_mask),
        .prune_cnt  (prune_cnt),
        .busy       (busy),
        .done       (done)
    );

    head_prune_ctrl #(
        .NUM_TILES (1),
        .NUM_HEADS (1),
        .ACC_LAT   (0)
    ) dut6 (
        .clk        (clk),
        .reset      (reset),
        .start      (start6),
        .bus        (bus6),
        .head_idx   (head_idx6),
        .prune_mask (prune_mask6),
        .prune_cnt  (prune_cnt6),
        .busy       (busy6),
        .done       (done6)
    );

    always #5 clk = ~clk;

    // Accumulator stand-in: decision per head, or the inverted-outside-CAPTURE pattern.
    logic          capture_q = 1'b0;
    logic          t5_mode   = 1'b0;
    logic [NH-1:0] prune_pat = '0;
    always @(posedge clk) capture_q <= bus.acc_compare;
    assign bus.acc_prune = t5_mode ? ~capture_q : prune_pat[head_idx];

    // Activity monitor for the default instance.
    logic clr_stats = 1'b1;
    logic toggle    = 1'b0;
    int   en_cnt  [NH];
    int   rdy_cnt [NH];
    int   clr_cyc [NH];
    int   cyc      = 0;
    int   done_cnt = 0;
    int   spurious = 0;
    int   overlap  = 0;
    always @(posedge clk) begin
        if (clr_stats) begin
            for (int i = 0; i < NH; i++) begin
                en_cnt[i]  <= 0;
                rdy_cnt[i] <= 0;
                clr_cyc[i] <= 0;
            end
            done_cnt <= 0;
            spurious <= 0;
        end else begin
            if (bus.acc_enable === 1'b1) en_cnt[head_idx] <= en_cnt[head_idx] + 1;
            if (bus.tile_ready === 1'b1) rdy_cnt[head_idx] <= rdy_cnt[head_idx] + 1;
            if (bus.acc_clear === 1'b1) clr_cyc[head_idx] <= cyc;
            if (bus.acc_enable !== (bus.tile_valid & bus.tile_ready)) spurious <= spurious + 1;
            if (done === 1'b1) done_cnt <= done_cnt + 1;
        end
        if ((done & busy) === 1'b1 || (done6 & busy6) === 1'b1) overlap <= overlap + 1;
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (toggle) bus.tile_valid = ~bus.tile_valid;
    endtask

    task automatic clear_stats();
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [NH-1:0] pat);
        exp_t e;
        e.mask = pat;
        e.cnt  = (HW+1)'($countones(pat));
        sb.push_back(e);
    endtask

    // lat counts cycles from the start cycle (cycle 0) to the cycle showing done.
    task automatic wait_done(input string tag, input int budget, output int lat);
        exp_t e;
        lat = 1;
        while (done !== 1'b1 && lat < budget) begin
            step();
            lat++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk({tag, "_mask"}, 32'(prune_mask), 32'(e.mask));
                chk({tag, "_cnt"}, 32'(prune_cnt), 32'(e.cnt));
            end
        end
    endtask

    task automatic wait_head_accum(input string tag, input logic [HW-1:0] h, input int budget);
        int n;
        n = 0;
        while (!(head_idx === h && bus.tile_ready === 1'b1) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_reach_head"}, 32'(head_idx === h && bus.tile_ready === 1'b1), 32'd1);
    endtask

    initial begin
        int lat;
        int span;
        logic ok;

        reset           = 1'b1;
        start           = 1'b0;
        start6          = 1'b0;
        bus.tile_valid  = 1'b0;
        bus6.tile_valid = 1'b0;
        bus6.acc_prune  = 1'b1;
        repeat (3) step();

        // Reset state of both instances.
        chk("rst_outputs", 32'({head_idx, prune_mask, prune_cnt, busy, done, bus.tile_ready,
                                bus.acc_clear, bus.acc_enable, bus.acc_compare}), 32'd0);
        chk("rst_outputs6", 32'({head_idx6, prune_mask6, prune_cnt6, busy6, done6, bus6.tile_ready,
                                 bus6.acc_clear, bus6.acc_enable, bus6.acc_compare}), 32'd0);
        reset = 1'b0;
        step();

        // T1: no stalls, heads 1 and 5 pruned.
        prune_pat      = 8'b0010_0010;
        bus.tile_valid = 1'b1;
        clear_stats();
        push_exp(prune_pat);
        pulse_start();
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done("t1", 400, lat);
        chk("t1_latency", 32'(lat), 32'(NH * (1 + NT + AL + 2) + 1));
        chk("t1_busy_at_done", 32'(busy), 32'd0);
        step();
        chk("t1_done_pulse", 32'(done), 32'd0);
        repeat (3) step();
        chk("t1_mask_hold", 32'(prune_mask), 32'h22);
        chk("t1_cnt_hold", 32'(prune_cnt), 32'd2);
        chk("t1_done_count", 32'(done_cnt), 32'd1);
        for (int h = 0; h < NH; h++) chk($sformatf("t1_en_h%0d", h), 32'(en_cnt[h]), 32'(NT));
        for (int h = 1; h < NH; h++)
            chk($sformatf("t1_span_h%0d", h - 1), 32'(clr_cyc[h] - clr_cyc[h - 1]), 32'(1 + NT + AL + 2));
        chk("t1_spurious", 32'(spurious), 32'd0);

        // T2: tile_valid toggles every cycle; each head still sees exactly NT enables.
        prune_pat      = 8'b1100_0001;
        bus.tile_valid = 1'b0;
        toggle         = 1'b1;
        clear_stats();
        push_exp(prune_pat);
        pulse_start();
        wait_done("t2", 800, lat);
        toggle = 1'b0;
        step();
        for (int h = 0; h < NH; h++) chk($sformatf("t2_en_h%0d", h), 32'(en_cnt[h]), 32'(NT));
        // ACCUM lasts 2*NT or 2*NT-1 cycles depending on the valid phase at entry.
        for (int h = 1; h < NH; h++) begin
            span = clr_cyc[h] - clr_cyc[h - 1];
            ok   = (span == 1 + rdy_cnt[h - 1] + int'(AL) + 2) &&
                   (rdy_cnt[h - 1] >= int'(2 * NT - 1)) && (rdy_cnt[h - 1] <= int'(2 * NT));
            chk($sformatf("t2_span_h%0d_is_%0d", h - 1, span), 32'(ok), 32'd1);
        end
        chk("t2_spurious", 32'(spurious), 32'd0);

        // T3: start re-pulsed during head 2 ACCUM is ignored.
        prune_pat      = 8'b0100_0011;
        bus.tile_valid = 1'b1;
        clear_stats();
        push_exp(prune_pat);
        pulse_start();
        wait_head_accum("t3", 3'd2, 200);
        pulse_start();
        chk("t3_head_kept", 32'(head_idx), 32'd2);
        chk("t3_mask_low_kept", 32'(prune_mask[1:0]), 32'd3);
        chk("t3_still_accum", 32'(bus.tile_ready), 32'd1);
        wait_done("t3", 400, lat);
        step();
        chk("t3_single_done", 32'(done_cnt), 32'd1);

        // T4: reset during head 3 ACCUM, with start in the same cycle; reset wins.
        prune_pat = 8'b0000_0111;
        pulse_start();
        wait_head_accum("t4", 3'd3, 200);
        chk("t4_mask_before_reset", 32'(prune_mask), 32'h07);
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        chk("t4_rst_outputs", 32'({head_idx, prune_mask, prune_cnt, busy, done, bus.tile_ready,
                                   bus.acc_clear, bus.acc_enable, bus.acc_compare}), 32'd0);
        step();
        chk("t4_stays_idle", 32'(busy), 32'd0);
        prune_pat = 8'b1000_0000;
        push_exp(prune_pat);
        pulse_start();
        chk("t4_restart_state", 32'({head_idx, prune_mask, bus.acc_clear}), 32'd1);
        wait_done("t4", 400, lat);

        // T5: acc_prune high everywhere except CAPTURE must not mark any head.
        t5_mode = 1'b1;
        push_exp(8'h00);
        pulse_start();
        wait_done("t5", 400, lat);
        t5_mode = 1'b0;
        step();

        // T6: one head, one tile, no drain.
        bus6.tile_valid = 1'b1;
        start6 = 1'b1;
        step();
        start6 = 1'b0;
        chk("t6_clear", 32'({bus6.acc_clear, bus6.tile_ready, bus6.acc_enable, bus6.acc_compare,
                             busy6, done6}), 32'b100010);
        step();
        chk("t6_accum", 32'({bus6.acc_clear, bus6.tile_ready, bus6.acc_enable, bus6.acc_compare,
                             busy6, done6}), 32'b011010);
        step();
        chk("t6_compare", 32'({bus6.acc_clear, bus6.tile_ready, bus6.acc_enable, bus6.acc_compare,
                               busy6, done6}), 32'b000110);
        step();
        chk("t6_capture", 32'({bus6.acc_clear, bus6.tile_ready, bus6.acc_enable, bus6.acc_compare,
                               busy6, done6}), 32'b000010);
        step();
        chk("t6_done", 32'({bus6.acc_clear, bus6.tile_ready, bus6.acc_enable, bus6.acc_compare,
                            busy6, done6}), 32'b000001);
        chk("t6_result", 32'({head_idx6, prune_mask6, prune_cnt6}), 32'b0101);
        step();

        chk("done_busy_overlap", 32'(overlap), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
